// File: rtl/periph_plug_demux.sv
// periph_plug_demux: address decoder steering one peripheral request stream to NB_PLUGS slave plugs, in-order responses, error reply for unmapped plugs
module periph_plug_demux #(
    parameter int NB_PLUGS = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W = 5,
    parameter int SEL_LSB = 10,
    parameter int SEL_W = 4,
    parameter int MAX_OUTST = 4,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'hBADACCE5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       m_req_i,
    input  logic [ADDR_W-1:0]          m_add_i,
    input  logic                       m_wen_i,
    input  logic [DATA_W-1:0]          m_wdata_i,
    input  logic [DATA_W/8-1:0]        m_be_i,
    input  logic [ID_W-1:0]            m_id_i,
    output logic                       m_gnt_o,
    output logic                       m_r_valid_o,
    output logic [DATA_W-1:0]          m_r_rdata_o,
    output logic                       m_r_opc_o,
    output logic [ID_W-1:0]            m_r_id_o,
    output logic [NB_PLUGS-1:0]        s_req_o,
    output logic [ADDR_W-1:0]          s_add_o,
    output logic                       s_wen_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    output logic [DATA_W/8-1:0]        s_be_o,
    output logic [ID_W-1:0]            s_id_o,
    input  logic [NB_PLUGS-1:0]        s_gnt_i,
    input  logic [NB_PLUGS-1:0]        s_r_valid_i,
    input  logic [NB_PLUGS*DATA_W-1:0] s_r_rdata_i,
    input  logic [NB_PLUGS-1:0]        s_r_opc_i,
    input  logic [NB_PLUGS*ID_W-1:0]   s_r_id_i
);
    localparam int PW = NB_PLUGS > 1 ? $clog2(NB_PLUGS) : 1;
    localparam int TW = $clog2(NB_PLUGS + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [SEL_W-1:0]    sel;
    logic                mapped;
    logic [PW-1:0]       pidx;
    logic [PW-1:0]       cidx;
    logic [TW-1:0]       tgt;
    logic [TW-1:0]       cur_tgt;
    logic                cur_map;
    logic [OW-1:0]       outst;
    logic                err_pend;
    logic [ID_W-1:0]     err_id;
    logic                stall;
    logic                xfer;
    logic                plug_rsp;
    logic                rsp;
    logic [NB_PLUGS-1:0] rsp_ok;

    // The unmapped target is the virtual index NB_PLUGS so it takes part in the same-target gate
    assign sel      = m_add_i[SEL_LSB +: SEL_W];
    assign mapped   = 32'(sel) < NB_PLUGS;
    assign pidx     = PW'(sel);
    assign tgt      = mapped ? TW'(sel) : TW'(NB_PLUGS);
    assign cidx     = PW'(cur_tgt);
    assign cur_map  = 32'(cur_tgt) < NB_PLUGS;
    assign stall    = outst == OW'(MAX_OUTST) || (outst != '0 && tgt != cur_tgt);
    assign m_gnt_o  = rst_ni && !stall && (mapped ? s_gnt_i[pidx] : m_req_i);
    assign xfer     = m_req_i && m_gnt_o;
    assign s_req_o  = (rst_ni && mapped && !stall && m_req_i) ? NB_PLUGS'(1) << pidx : '0;

    assign s_add_o   = rst_ni ? m_add_i : '0;
    assign s_wen_o   = rst_ni && m_wen_i;
    assign s_wdata_o = rst_ni ? m_wdata_i : '0;
    assign s_be_o    = rst_ni ? m_be_i : '0;
    assign s_id_o    = rst_ni ? m_id_i : '0;

    // Only the current target may answer, and only while something is outstanding
    assign rsp_ok      = (cur_map && outst != '0) ? NB_PLUGS'(1) << cidx : '0;
    assign plug_rsp    = |(s_r_valid_i & rsp_ok);
    assign rsp         = rst_ni && (err_pend || plug_rsp);
    assign m_r_valid_o = rsp;
    assign m_r_opc_o   = rst_ni && (err_pend || (plug_rsp && s_r_opc_i[cidx]));
    assign m_r_rdata_o = !rsp ? '0 : err_pend ? ERR_RDATA : s_r_rdata_i[int'(cidx)*DATA_W +: DATA_W];
    assign m_r_id_o    = !rsp ? '0 : err_pend ? err_id : s_r_id_i[int'(cidx)*ID_W +: ID_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_tgt  <= '0;
            outst    <= '0;
            err_pend <= 1'b0;
            err_id   <= '0;
        end else begin
            if (xfer) cur_tgt <= tgt;
            outst    <= outst + OW'(xfer) - OW'(rsp);
            err_pend <= xfer && !mapped;
            if (xfer && !mapped) err_id <= m_id_i;
        end
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        m_req_i && !m_gnt_o |=> $stable({m_add_i, m_wen_i, m_wdata_i, m_be_i, m_id_i}));
    a_rsp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (s_r_valid_i & ~rsp_ok) == '0);
endmodule
